// File: rtl/pong_mem_arbiter.sv
// ============================================================================
// Module   : pong_mem_arbiter
// Purpose  : Shares one single-port 32-bit on-chip RAM between two requesters.
//            Port A (video scan-out fetch, read-only) has priority; port B
//            (game logic, read/write) is forced through after MAX_STREAK
//            consecutive contested A wins. Grants are decided combinationally
//            and drive the RAM pins in the same cycle; read data returns to
//            the winner one cycle later. Out-of-range accesses consume their
//            slot without touching the RAM and are flagged with x_err.
// Ports    : clk, reset_n          - clock, asynchronous active-low reset
//            a_req/a_addr          - A request (held until a_gnt)
//            a_gnt/a_rvalid/a_rdata/a_err - A grant and read response
//            b_req/b_we/b_addr/b_be/b_wdata - B request (held until b_gnt)
//            b_gnt/b_rvalid/b_rdata/b_err - B grant and response
//            mem_*                 - RAM address/control/data pins
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pong_mem_arbiter #(
  parameter int DEPTH      = 3000,
  parameter int AW         = 12,
  parameter int MAX_STREAK = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  // Port A: video fetch, read-only
  input  logic          a_req,
  input  logic [AW-1:0] a_addr,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [31:0]   a_rdata,
  output logic          a_err,
  // Port B: game logic, read/write
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [3:0]    b_be,
  input  logic [31:0]   b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [31:0]   b_rdata,
  output logic          b_err,
  // RAM side
  output logic [AW-1:0] mem_address,
  output logic [3:0]    mem_byteenable,
  output logic          mem_chipselect,
  output logic          mem_write,
  output logic [31:0]   mem_writedata,
  output logic          mem_clken,
  input  logic [31:0]   mem_readdata
);

  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] c_max_streak = SW'(MAX_STREAK);
  // One extra bit so DEPTH == 2**AW still compares correctly.
  localparam logic [AW:0]   c_depth      = (AW + 1)'(DEPTH);

  // Which requester owns the RAM read data returning next cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_e;

  logic          rdy_q;
  logic [SW-1:0] streak_q, streak_d;
  owner_e        rd_owner_q, rd_owner_d;
  logic          a_rv_q, a_rv_d;
  logic          a_err_q, a_err_d;
  logic          b_rv_q, b_rv_d;
  logic          b_err_q, b_err_d;

  logic          w_a_oor;
  logic          w_b_oor;
  logic          w_force_b;

  // --------------------------------------------------------------------------
  // Sequential state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_q      <= 1'b0;
      streak_q   <= '0;
      rd_owner_q <= OWN_NONE;
      a_rv_q     <= 1'b0;
      a_err_q    <= 1'b0;
      b_rv_q     <= 1'b0;
      b_err_q    <= 1'b0;
    end else begin
      rdy_q      <= 1'b1;
      streak_q   <= streak_d;
      rd_owner_q <= rd_owner_d;
      a_rv_q     <= a_rv_d;
      a_err_q    <= a_err_d;
      b_rv_q     <= b_rv_d;
      b_err_q    <= b_err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Arbitration, RAM drive and next-state
  // --------------------------------------------------------------------------
  always_comb begin
    w_a_oor        = ({1'b0, a_addr} >= c_depth);
    w_b_oor        = ({1'b0, b_addr} >= c_depth);
    w_force_b      = (streak_q == c_max_streak);

    // A wins unless B is also waiting and A has used up its streak.
    a_gnt          = rdy_q & a_req & ~(b_req & w_force_b);
    b_gnt          = rdy_q & b_req & ~a_gnt;

    mem_address    = '0;
    mem_byteenable = 4'h0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_writedata  = 32'h0;

    rd_owner_d     = OWN_NONE;
    a_rv_d         = 1'b0;
    a_err_d        = 1'b0;
    b_rv_d         = 1'b0;
    b_err_d        = 1'b0;

    if (a_gnt) begin
      mem_address    = a_addr;
      mem_byteenable = 4'hF;
      mem_chipselect = ~w_a_oor;
      a_rv_d         = 1'b1;
      a_err_d        = w_a_oor;
      rd_owner_d     = w_a_oor ? OWN_NONE : OWN_A;
    end else if (b_gnt) begin
      mem_address    = b_addr;
      mem_byteenable = b_we ? b_be : 4'hF;
      mem_chipselect = ~w_b_oor;
      // Out-of-range writes are dropped: no write strobe reaches the RAM.
      mem_write      = b_we & ~w_b_oor;
      mem_writedata  = b_we ? b_wdata : 32'h0;
      b_rv_d         = ~b_we;
      b_err_d        = w_b_oor;
      rd_owner_d     = (b_we || w_b_oor) ? OWN_NONE : OWN_B;
    end

    // Streak counts only contested A wins; any B grant or B idle resets it.
    streak_d = streak_q;
    if (!b_req || b_gnt) begin
      streak_d = '0;
    end else if (a_gnt && (streak_q != c_max_streak)) begin
      streak_d = streak_q + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Responses. Out-of-range reads never set rd_owner, so their data is zero.
  // --------------------------------------------------------------------------
  assign mem_clken = rdy_q;
  assign a_rvalid  = a_rv_q;
  assign a_err     = a_err_q;
  assign a_rdata   = (rd_owner_q == OWN_A) ? mem_readdata : 32'h0;
  assign b_rvalid  = b_rv_q;
  assign b_err     = b_err_q;
  assign b_rdata   = (rd_owner_q == OWN_B) ? mem_readdata : 32'h0;

endmodule

`default_nettype wire
